// File: rtl/spi_master_msg_if.sv
// Host request/response, frame select and byte-engine handshake for spi_master_msg.
// The master modport is the message-layer side; slave is the host/byte-engine side.
interface spi_master_msg_if;
  logic        reqValid;
  logic        reqReady;
  logic [1:0]  reqOp;
  logic [3:0]  reqRegId;
  logic [31:0] reqWData;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspErr;
  logic        csN;
  logic        txValid;
  logic        txReady;
  logic [7:0]  tx;
  logic        rxValid;
  logic [7:0]  rx;

  modport master (
    input  reqValid, reqOp, reqRegId, reqWData, txReady, rxValid, rx,
    output reqReady, rspValid, rspData, rspErr, csN, txValid, tx
  );

  modport slave (
    output reqValid, reqOp, reqRegId, reqWData, txReady, rxValid, rx,
    input  reqReady, rspValid, rspData, rspErr, csN, txValid, tx
  );
endinterface

// File: rtl/spi_master_msg.sv
// Message-layer SPI initiator: turns one status/read/write request into a byte sequence.
// Optional receive timeout in WAIT is enabled by defining SPI_MSG_TIMEOUT_EN.
module spi_master_msg #(
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  STATUS_EXPECT  = 8'h5A
) (
  input logic             sysClk,
  input logic             usrReset,
  spi_master_msg_if.master bus
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, GAP, DONE} state_t;
  typedef enum logic [1:0] {
    OP_STATUS = 2'b00,
    OP_RSVD   = 2'b01,
    OP_READ   = 2'b10,
    OP_WRITE  = 2'b11
  } op_t;

  state_t      state;
  op_t         opQ;
  logic [3:0]  regIdQ;
  logic [31:0] wdataQ;
  logic [2:0]  byteCnt;
  logic [31:0] accum;
  logic [31:0] accNext;
  logic [2:0]  lastIdx;
  logic [31:0] gapCnt;
  logic        reqReadyQ;
  logic        rspValidQ;
  logic [31:0] rspDataQ;
  logic        rspErrQ;
  logic        csNQ;
  logic        txValidQ;
  logic [7:0]  txQ;
`ifdef SPI_MSG_TIMEOUT_EN
  logic [31:0] toCnt;
`endif

  function automatic logic [7:0] txByte(op_t op, logic [3:0] id, logic [31:0] wd,
                                        logic [2:0] idx);
    logic [7:0] b;
    b = '0;
    case (idx)
      3'd0: begin
        if (op == OP_READ)  b = {4'b1000, id};
        if (op == OP_WRITE) b = {4'b1100, id};
      end
      3'd1: if (op == OP_WRITE) b = wd[31:24];
      3'd2: if (op == OP_WRITE) b = wd[23:16];
      3'd3: if (op == OP_WRITE) b = wd[15:8];
      3'd4: if (op == OP_WRITE) b = wd[7:0];
      default: b = '0;
    endcase
    return b;
  endfunction

  assign lastIdx = (opQ == OP_STATUS) ? 3'd1 : 3'd4;

  // Received bytes land at fixed positions so a truncated read keeps zeros in the missing slots.
  always_comb begin
    accNext = accum;
    if (opQ == OP_STATUS && byteCnt == 3'd1) accNext[7:0] = bus.rx;
    if (opQ == OP_READ) begin
      case (byteCnt)
        3'd1:    accNext[31:24] = bus.rx;
        3'd2:    accNext[23:16] = bus.rx;
        3'd3:    accNext[15:8]  = bus.rx;
        3'd4:    accNext[7:0]   = bus.rx;
        default: accNext = accum;
      endcase
    end
  end

  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      state     <= IDLE;
      opQ       <= OP_STATUS;
      regIdQ    <= '0;
      wdataQ    <= '0;
      byteCnt   <= '0;
      accum     <= '0;
      gapCnt    <= '0;
      reqReadyQ <= 1'b1;
      rspValidQ <= 1'b0;
      rspDataQ  <= '0;
      rspErrQ   <= 1'b0;
      csNQ      <= 1'b1;
      txValidQ  <= 1'b0;
      txQ       <= '0;
`ifdef SPI_MSG_TIMEOUT_EN
      toCnt     <= '0;
`endif
    end else begin
      rspValidQ <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.reqValid) begin
            opQ       <= op_t'(bus.reqOp);
            regIdQ    <= bus.reqRegId;
            wdataQ    <= bus.reqWData;
            byteCnt   <= '0;
            accum     <= '0;
            reqReadyQ <= 1'b0;
            if (op_t'(bus.reqOp) == OP_RSVD) begin
              state     <= DONE;
              rspValidQ <= 1'b1;
              rspDataQ  <= '0;
              rspErrQ   <= 1'b1;
            end else begin
              state    <= SEND;
              csNQ     <= 1'b0;
              txValidQ <= 1'b1;
              txQ      <= txByte(op_t'(bus.reqOp), bus.reqRegId, bus.reqWData, 3'd0);
            end
          end
        end
        SEND: begin
          if (bus.txReady) begin
            txValidQ <= 1'b0;
            state    <= WAIT;
`ifdef SPI_MSG_TIMEOUT_EN
            toCnt    <= '0;
`endif
          end
        end
        WAIT: begin
          if (bus.rxValid) begin
            accum   <= accNext;
            byteCnt <= byteCnt + 3'd1;
            if (byteCnt == lastIdx) begin
              state     <= DONE;
              rspValidQ <= 1'b1;
              rspDataQ  <= accNext;
              rspErrQ   <= (opQ == OP_STATUS) ? (accNext[7:0] != STATUS_EXPECT) : 1'b0;
              csNQ      <= 1'b1;
            end else if (GAP_CYCLES == 0) begin
              state    <= SEND;
              txValidQ <= 1'b1;
              txQ      <= txByte(opQ, regIdQ, wdataQ, byteCnt + 3'd1);
            end else begin
              state  <= GAP;
              gapCnt <= '0;
            end
          end
`ifdef SPI_MSG_TIMEOUT_EN
          else if (toCnt + 32'd1 >= TIMEOUT_CYCLES) begin
            state     <= DONE;
            rspValidQ <= 1'b1;
            rspDataQ  <= accum;
            rspErrQ   <= 1'b1;
            csNQ      <= 1'b1;
            txValidQ  <= 1'b0;
          end else begin
            toCnt <= toCnt + 32'd1;
          end
`endif
        end
        GAP: begin
          // byteCnt already points at the next byte here.
          if (gapCnt == GAP_CYCLES - 32'd1) begin
            state    <= SEND;
            txValidQ <= 1'b1;
            txQ      <= txByte(opQ, regIdQ, wdataQ, byteCnt);
          end else begin
            gapCnt <= gapCnt + 32'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          reqReadyQ <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.reqReady = reqReadyQ;
  assign bus.rspValid = rspValidQ;
  assign bus.rspData  = rspDataQ;
  assign bus.rspErr   = rspErrQ;
  assign bus.csN      = csNQ;
  assign bus.txValid  = txValidQ;
  assign bus.tx       = txQ;

endmodule

// File: tb/tb_spi_master_msg.sv
// Directed bench for spi_master_msg with a request-level model, byte responder and per-cycle compare.
module tb_spi_master_msg;
  logic sysClk = 1'b0;
  logic usrReset;

  spi_master_msg_if bus();

  spi_master_msg #(
    .GAP_CYCLES(0),
    .TIMEOUT_CYCLES(16),
    .STATUS_EXPECT(8'h5A)
  ) dut (
    .sysClk(sysClk),
    .usrReset(usrReset),
    .bus(bus)
  );

  always #5 sysClk = ~sysClk;

  int nVec = 0;
  int nFail = 0;

  logic [7:0]  expTxQ[$];
  logic [7:0]  rxQ[$];
  logic [31:0] expData;
  logic        expErr;
  int          expCnt;
  bit          msgActive = 0;
  bit          rspExpected = 0;
  bit          rspSeen = 0;
  int          rIdx = 0;
  int          pend = 0;
  logic [7:0]  pendByte = 8'h00;
  int          holdFrom = 99;
  int          stallAt = -1;
  int          stallLeft = 0;
  longint      cyc = 0;
  longint      accCyc = 0;
  longint      rspCyc = 0;
  logic [39:0] txLog = '0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte-engine responder: records accepted bytes, answers rxValid two cycles later.
  always @(posedge sysClk) begin
    cyc++;
    if (!usrReset && bus.txValid && bus.txReady) begin
      txLog = {txLog[31:0], bus.tx};
      if (rIdx < holdFrom) begin
        pend = 2;
        pendByte = (rIdx < rxQ.size()) ? rxQ[rIdx] : 8'h00;
      end
      rIdx++;
      accCyc = cyc;
    end
  end

  always @(negedge sysClk) begin
    bus.rxValid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.rxValid = 1'b1;
        bus.rx = pendByte;
      end
    end
    if (bus.txValid && rIdx == stallAt && stallLeft > 0) begin
      bus.txReady = 1'b0;
      stallLeft--;
    end else begin
      bus.txReady = 1'b1;
    end
  end

  // Compare process against the request-level model.
  always @(negedge sysClk) begin
    if (!usrReset) begin
      if (bus.txValid) begin
        if (msgActive && rIdx < expTxQ.size()) begin
          chk("tx_byte", 40'(bus.tx), 40'(expTxQ[rIdx]));
          chk("csN_with_tx", 40'(bus.csN), 40'd0);
        end else begin
          chk("unexpected_txValid", 40'(bus.txValid), 40'd0);
        end
      end
      if (msgActive && rIdx > 0 && !rspSeen && !bus.rspValid)
        chk("csN_in_frame", 40'(bus.csN), 40'd0);
      if (msgActive && expTxQ.size() == 0)
        chk("csN_reserved", 40'(bus.csN), 40'd1);
      if (bus.rspValid) begin
        if (rspExpected && !rspSeen) begin
          chk("rspData", 40'(bus.rspData), 40'(expData));
          chk("rspErr", 40'(bus.rspErr), 40'(expErr));
          chk("byte_count", 40'(rIdx), 40'(expCnt));
          chk("csN_done", 40'(bus.csN), 40'd1);
          chk("reqReady_in_done", 40'(bus.reqReady), 40'd0);
        end else begin
          chk("spurious_rspValid", 40'(bus.rspValid), 40'd0);
        end
        rspSeen = 1;
      end
    end
  end

  // rx holds exchange bytes 0..4 from MSB down.
  task automatic startReq(input logic [1:0] op, input logic [3:0] id,
                          input logic [31:0] wd, input logic [39:0] rx);
    int n;
    rxQ = '{rx[39:32], rx[31:24], rx[23:16], rx[15:8], rx[7:0]};
    case (op)
      2'b00: begin
        expTxQ = '{8'h00, 8'h00};
        expData = {24'h0, rx[31:24]};
        expErr = (rx[31:24] != 8'h5A);
      end
      2'b10: begin
        expTxQ = '{8'h80 | {4'h0, id}, 8'h00, 8'h00, 8'h00, 8'h00};
        expData = rx[31:0];
        expErr = 1'b0;
      end
      2'b11: begin
        expTxQ = '{8'hC0 | {4'h0, id}, wd[31:24], wd[23:16], wd[15:8], wd[7:0]};
        expData = 32'h0;
        expErr = 1'b0;
      end
      default: begin
        expTxQ = {};
        expData = 32'h0;
        expErr = 1'b1;
      end
    endcase
    expCnt = expTxQ.size();
    rIdx = 0;
    rspSeen = 0;
    txLog = '0;
    n = 0;
    while (!bus.reqReady && n < 50) begin
      @(negedge sysClk);
      n++;
    end
    chk("reqReady_idle", 40'(bus.reqReady), 40'd1);
    chk("csN_between", 40'(bus.csN), 40'd1);
    msgActive = 1;
    rspExpected = 1;
    bus.reqValid = 1'b1;
    bus.reqOp = op;
    bus.reqRegId = id;
    bus.reqWData = wd;
    @(negedge sysClk);
    bus.reqValid = 1'b0;
    chk("reqReady_busy", 40'(bus.reqReady), 40'd0);
  endtask

  task automatic waitRsp(output int lat);
    int n;
    n = 0;
    while (!bus.rspValid && n < 200) begin
      @(negedge sysClk);
      n++;
    end
    lat = n;
    rspCyc = cyc;
    if (n >= 200) chk("rsp_timeout", 40'(bus.rspValid), 40'd1);
    @(negedge sysClk);
    chk("rsp_pulse_width", 40'(bus.rspValid), 40'd0);
    chk("reqReady_after", 40'(bus.reqReady), 40'd1);
    msgActive = 0;
    rspExpected = 0;
  endtask

  initial begin
    int lat;
    int n;
    usrReset = 1'b1;
    bus.reqValid = 1'b0;
    bus.reqOp = 2'b00;
    bus.reqRegId = 4'h0;
    bus.reqWData = 32'h0;
    bus.txReady = 1'b1;
    bus.rxValid = 1'b0;
    bus.rx = 8'h00;
    repeat (2) @(negedge sysClk);
    chk("rst_reqReady", 40'(bus.reqReady), 40'd1);
    chk("rst_rspValid", 40'(bus.rspValid), 40'd0);
    chk("rst_rspData", 40'(bus.rspData), 40'd0);
    chk("rst_rspErr", 40'(bus.rspErr), 40'd0);
    chk("rst_csN", 40'(bus.csN), 40'd1);
    chk("rst_txValid", 40'(bus.txValid), 40'd0);
    chk("rst_tx", 40'(bus.tx), 40'd0);
    usrReset = 1'b0;
    @(negedge sysClk);

    // Write reg 3
    startReq(2'b11, 4'd3, 32'hDEADBEEF, 40'h0);
    waitRsp(lat);
    chk("wr_txlog", txLog, 40'hC3DEADBEEF);
    chk("wr_rspData_lit", 40'(bus.rspData), 40'd0);

    // Read reg 5
    startReq(2'b10, 4'd5, 32'h0, 40'hEE12345678);
    waitRsp(lat);
    chk("rd_txlog", txLog, 40'h8500000000);
    chk("rd_rspData_lit", 40'(bus.rspData), 40'h12345678);
    chk("rd_rspErr_lit", 40'(bus.rspErr), 40'd0);

    // Status twice
    startReq(2'b00, 4'd0, 32'h0, 40'h335A000000);
    waitRsp(lat);
    chk("st1_lit", 40'({bus.rspErr, bus.rspData}), 40'h00_0000005A);
    startReq(2'b00, 4'd0, 32'h0, 40'h005B000000);
    waitRsp(lat);
    chk("st2_lit", 40'({bus.rspErr, bus.rspData}), 40'h01_0000005B);
    repeat (3) @(negedge sysClk);
    chk("rsp_hold", 40'(bus.rspData), 40'h5B);

    // Stalled write with a request pulsed while busy
    stallAt = 2;
    stallLeft = 3;
    startReq(2'b11, 4'd3, 32'hDEADBEEF, 40'h0);
    repeat (3) @(negedge sysClk);
    bus.reqValid = 1'b1;
    bus.reqOp = 2'b10;
    bus.reqRegId = 4'hF;
    @(negedge sysClk);
    bus.reqValid = 1'b0;
    waitRsp(lat);
    stallAt = -1;
    chk("stall_txlog", txLog, 40'hC3DEADBEEF);
    chk("stall_consumed", 40'(stallLeft), 40'd0);
    repeat (4) @(negedge sysClk);
    chk("busy_req_ignored", 40'(bus.txValid), 40'd0);

    // Reserved op
    startReq(2'b01, 4'd7, 32'h0, 40'h0);
    waitRsp(lat);
    chk("rsvd_latency", 40'(lat), 40'd0);
    chk("rsvd_lit", 40'({bus.rspErr, bus.rspData}), 40'h01_00000000);

    // Reset in the middle of a read
    startReq(2'b10, 4'd5, 32'h0, 40'h0011223344);
    n = 0;
    while (rIdx < 3 && n < 100) begin
      @(negedge sysClk);
      n++;
    end
    chk("reset_reached_byte2", 40'(rIdx), 40'd3);
    usrReset = 1'b1;
    #1;
    chk("midrst_csN", 40'(bus.csN), 40'd1);
    chk("midrst_txValid", 40'(bus.txValid), 40'd0);
    chk("midrst_reqReady", 40'(bus.reqReady), 40'd1);
    chk("midrst_rspValid", 40'(bus.rspValid), 40'd0);
    msgActive = 0;
    rspExpected = 0;
    pend = 0;
    @(negedge sysClk);
    usrReset = 1'b0;
    repeat (6) @(negedge sysClk);
    chk("postrst_quiet", 40'({bus.txValid, bus.csN}), 40'h1);
    startReq(2'b00, 4'd0, 32'h0, 40'h005A000000);
    waitRsp(lat);
    chk("postrst_status", 40'({bus.rspErr, bus.rspData}), 40'h00_0000005A);

`ifdef SPI_MSG_TIMEOUT_EN
    holdFrom = 2;
    startReq(2'b10, 4'd5, 32'h0, 40'h0012345678);
    expData = 32'h12000000;
    expErr = 1'b1;
    expCnt = 3;
    waitRsp(lat);
    holdFrom = 99;
    chk("timeout_latency", 40'(rspCyc - accCyc), 40'd16);
    chk("timeout_lit", 40'({bus.rspErr, bus.rspData}), 40'h01_12000000);
`endif

    repeat (3) @(negedge sysClk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
